ascon_program_sequencer: RTL and testbench
==========================================

Name: ascon_program_sequencer

Overview:
Hardware replacement for the bench-driven instruction flow of the ASCON system core. Fetches 6-bit opcodes from a program memory, feeds data/text blocks from two block memories, and drives the core's instruction and block-enable inputs. Waits on the core's ready bit (status_reg[0]) between steps and captures FIFO-pull results into an output stream. Sits between a host/CPU start interface and ASCON_System_no_io_compression.

Parameters:
WIDTH, 128, block width (data, text, ascon_out)
PC_W, 5, program-memory address width
BLK_W, 3, data/text memory address width
OP_DATA_PUSH, 6'h01, opcode that pushes a data block
OP_TXT_PUSH, 6'h02, opcode that pushes a text block
OP_OUT_PULL, 6'h03, opcode that pulls one output block
OP_HALT, 6'h3f, end of program; also the idle opcode
TMO_W, 16, watchdog counter width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  synchronous active-low reset
start  in  1  1-cycle pulse; begin program at prog_base (ignored unless IDLE)
prog_base  in  PC_W  first program address
busy  out  1  high from accepted start until DONE/ERROR
done  out  1  1-cycle pulse when HALT reached
error  out  1  sticky until next start; watchdog expiry
imem_addr  out  PC_W  program memory address (1-cycle read latency)
imem_data  in  6  opcode at imem_addr, previous cycle
dmem_addr  out  BLK_W  data-block memory address
dmem_data  in  WIDTH  data block (1-cycle latency)
tmem_addr  out  BLK_W  text-block memory address
tmem_data  in  WIDTH  text block (1-cycle latency)
instruction  out  6  to core
data_block  out  WIDTH  to core
txt_block  out  WIDTH  to core
data_blk_en  out  1  to core, 1-cycle strobe
txt_blk_en  out  1  to core, 1-cycle strobe
core_next  in  1  core status_reg[0]
ascon_out  in  WIDTH  core output
out_data  out  WIDTH  captured pull result
out_valid  out  1  1-cycle strobe with out_data
out_index  out  BLK_W  pull ordinal of out_data, 0-based

Behaviour:
- Reset (rstn=0 at edge): state RST_WAIT, instruction=OP_HALT, all strobes/busy/done/error=0, pointers/addresses/out_data/out_index=0.
- RST_WAIT: stay until core_next=1 (core HW reset complete), then IDLE.
- IDLE: on start: imem_addr<=prog_base, dmem/tmem ptrs and pull count <=0, error<=0, busy<=1 -> FETCH.
- FETCH (1 cycle, memory latency) -> DECODE.
- DECODE: imem_data==OP_HALT -> DONE. Else instruction<=imem_data; DATA_PUSH: data_block<=dmem_data, data_blk_en<=1, dmem ptr++; TXT_PUSH: txt_block<=tmem_data, txt_blk_en<=1, tmem ptr++; -> SETTLE. dmem/tmem addresses always present current ptr so data is valid by DECODE.
- SETTLE (1 cycle): strobes drop to 0; core_next ignored (stale ready) -> WAIT.
- WAIT: until core_next=1. On that cycle: if opcode==OP_OUT_PULL, out_data<=ascon_out, out_valid=1 next cycle, out_index<=pull count, count++. imem_addr++ -> FETCH.
- Per-step minimum latency: 4 cycles (FETCH, DECODE, SETTLE, WAIT with immediate ready).
- DONE: instruction<=OP_HALT, done=1 for one cycle, busy<=0 -> IDLE.
- Pointer/PC wrap: modulo 2^width, no error; program is responsible for HALT.
- start while busy: ignored. Reset mid-program: abort immediately, return to RST_WAIT; no done.
- Strobe exclusivity: data_blk_en and txt_blk_en never high in the same cycle.

Optional Feature:
ASCON_SEQ_TIMEOUT_EN: defined -> TMO_W-bit counter cleared on entry to WAIT, increments each WAIT cycle; on all-ones without core_next: instruction<=OP_HALT, error<=1, busy<=0, state IDLE (no done). Not defined -> WAIT is unbounded, error tied 0.

Test Plan:
- Reset held 2 cycles, core_next rises at cycle 5 -> busy=0, instruction=6'h3f, start before cycle 5 ignored, accepted after.
- Program {DATA_PUSH x3, TXT_PUSH x4, HALT}, dmem[i]=i+1 -> data_blk_en 3 single-cycle pulses with data_block 1,2,3; txt_blk_en 4 pulses; done pulse; strobes never overlap.
- Program {OUT_PULL x4, HALT}, core returns ascon_out=0xA0..0xA3 -> out_valid 4 times, out_index 0..3, out_data matches.
- Core model asserts core_next 10 cycles after each instruction change -> each step exactly 13 cycles; stale core_next=1 during SETTLE ignored.
- rstn low during WAIT of step 3 -> strobes 0, instruction=6'h3f, no done; new start reruns from prog_base with ptrs at 0.
- ASCON_SEQ_TIMEOUT_EN, TMO_W=4, core_next held 0 -> error=1 after 15 WAIT cycles, busy=0, no done; next start clears error.

Source files
------------

// File: rtl/ascon_program_sequencer_if.sv
// Signal bundle between ascon_program_sequencer (master) and its host, program/block
// memories and the ASCON core (slave).
interface ascon_program_sequencer_if #(
  parameter int WIDTH = 128,
  parameter int PC_W  = 5,
  parameter int BLK_W = 3
);
  logic             start;
  logic [PC_W-1:0]  prog_base;
  logic             busy;
  logic             done;
  logic             error;
  logic [PC_W-1:0]  imem_addr;
  logic [5:0]       imem_data;
  logic [BLK_W-1:0] dmem_addr;
  logic [WIDTH-1:0] dmem_data;
  logic [BLK_W-1:0] tmem_addr;
  logic [WIDTH-1:0] tmem_data;
  logic [5:0]       instruction;
  logic [WIDTH-1:0] data_block;
  logic [WIDTH-1:0] txt_block;
  logic             data_blk_en;
  logic             txt_blk_en;
  logic             core_next;
  logic [WIDTH-1:0] ascon_out;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [BLK_W-1:0] out_index;

  modport master (
    input  start, prog_base, imem_data, dmem_data, tmem_data, core_next, ascon_out,
    output busy, done, error, imem_addr, dmem_addr, tmem_addr, instruction,
           data_block, txt_block, data_blk_en, txt_blk_en, out_data, out_valid, out_index
  );

  modport slave (
    output start, prog_base, imem_data, dmem_data, tmem_data, core_next, ascon_out,
    input  busy, done, error, imem_addr, dmem_addr, tmem_addr, instruction,
           data_block, txt_block, data_blk_en, txt_blk_en, out_data, out_valid, out_index
  );
endinterface

// File: rtl/ascon_program_sequencer.sv
// Program sequencer for the ASCON system core: fetches opcodes, pushes data/text blocks,
// waits on core ready and captures pulled outputs. Optional watchdog: ASCON_SEQ_TIMEOUT_EN.
module ascon_program_sequencer #(
  parameter int         WIDTH        = 128,
  parameter int         PC_W         = 5,
  parameter int         BLK_W        = 3,
  parameter logic [5:0] OP_DATA_PUSH = 6'h01,
  parameter logic [5:0] OP_TXT_PUSH  = 6'h02,
  parameter logic [5:0] OP_OUT_PULL  = 6'h03,
  parameter logic [5:0] OP_HALT      = 6'h3f,
  parameter int         TMO_W        = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  ascon_program_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_RST_WAIT,
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state,       w_state_next;
  logic [PC_W-1:0]  r_pc,          w_pc_next;
  logic [BLK_W-1:0] r_dptr,        w_dptr_next;
  logic [BLK_W-1:0] r_tptr,        w_tptr_next;
  logic [BLK_W-1:0] r_pull_cnt,    w_pull_cnt_next;
  logic [5:0]       r_instruction, w_instruction_next;
  logic [WIDTH-1:0] r_data_block,  w_data_block_next;
  logic [WIDTH-1:0] r_txt_block,   w_txt_block_next;
  logic             r_data_en,     w_data_en_next;
  logic             r_txt_en,      w_txt_en_next;
  logic             r_busy,        w_busy_next;
  logic             r_done,        w_done_next;
  logic [WIDTH-1:0] r_out_data,    w_out_data_next;
  logic             r_out_valid,   w_out_valid_next;
  logic [BLK_W-1:0] r_out_index,   w_out_index_next;
`ifdef ASCON_SEQ_TIMEOUT_EN
  logic             r_error,       w_error_next;
  logic [TMO_W-1:0] r_tmo,         w_tmo_next;
  logic [TMO_W-1:0] w_tmo_inc;
`endif

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_dptr_next        = r_dptr;
    w_tptr_next        = r_tptr;
    w_pull_cnt_next    = r_pull_cnt;
    w_instruction_next = r_instruction;
    w_data_block_next  = r_data_block;
    w_txt_block_next   = r_txt_block;
    w_data_en_next     = 1'b0;
    w_txt_en_next      = 1'b0;
    w_busy_next        = r_busy;
    w_done_next        = 1'b0;
    w_out_data_next    = r_out_data;
    w_out_valid_next   = 1'b0;
    w_out_index_next   = r_out_index;
`ifdef ASCON_SEQ_TIMEOUT_EN
    w_error_next       = r_error;
    w_tmo_next         = r_tmo;
    w_tmo_inc          = r_tmo + TMO_W'(1);
`endif

    case (r_state)
      S_RST_WAIT: begin
        if (bus.core_next) begin
          w_state_next = S_IDLE;
        end
      end

      S_IDLE: begin
        if (bus.start) begin
          w_pc_next       = bus.prog_base;
          w_dptr_next     = '0;
          w_tptr_next     = '0;
          w_pull_cnt_next = '0;
          w_busy_next     = 1'b1;
`ifdef ASCON_SEQ_TIMEOUT_EN
          w_error_next    = 1'b0;
`endif
          w_state_next    = S_FETCH;
        end
      end

      S_FETCH: begin
        w_state_next = S_DECODE;
      end

      // Block memories are addressed by the live pointers, so their data is valid here.
      S_DECODE: begin
        if (bus.imem_data == OP_HALT) begin
          w_done_next  = 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_instruction_next = bus.imem_data;
          if (bus.imem_data == OP_DATA_PUSH) begin
            w_data_block_next = bus.dmem_data;
            w_data_en_next    = 1'b1;
            w_dptr_next       = r_dptr + BLK_W'(1);
          end else if (bus.imem_data == OP_TXT_PUSH) begin
            w_txt_block_next = bus.tmem_data;
            w_txt_en_next    = 1'b1;
            w_tptr_next      = r_tptr + BLK_W'(1);
          end
          w_state_next = S_SETTLE;
        end
      end

      // The core has not yet seen the new instruction, so its ready bit is stale here.
      S_SETTLE: begin
`ifdef ASCON_SEQ_TIMEOUT_EN
        w_tmo_next   = '0;
`endif
        w_state_next = S_WAIT;
      end

      S_WAIT: begin
        if (bus.core_next) begin
          if (r_instruction == OP_OUT_PULL) begin
            w_out_data_next  = bus.ascon_out;
            w_out_valid_next = 1'b1;
            w_out_index_next = r_pull_cnt;
            w_pull_cnt_next  = r_pull_cnt + BLK_W'(1);
          end
          w_pc_next    = r_pc + PC_W'(1);
          w_state_next = S_FETCH;
        end
`ifdef ASCON_SEQ_TIMEOUT_EN
        else if (&w_tmo_inc) begin
          w_instruction_next = OP_HALT;
          w_error_next       = 1'b1;
          w_busy_next        = 1'b0;
          w_state_next       = S_IDLE;
        end else begin
          w_tmo_next = w_tmo_inc;
        end
`endif
      end

      S_DONE: begin
        w_instruction_next = OP_HALT;
        w_busy_next        = 1'b0;
        w_state_next       = S_IDLE;
      end

      default: begin
        w_state_next = S_RST_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_RST_WAIT;
      r_pc          <= '0;
      r_dptr        <= '0;
      r_tptr        <= '0;
      r_pull_cnt    <= '0;
      r_instruction <= OP_HALT;
      r_data_block  <= '0;
      r_txt_block   <= '0;
      r_data_en     <= 1'b0;
      r_txt_en      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_out_index   <= '0;
`ifdef ASCON_SEQ_TIMEOUT_EN
      r_error       <= 1'b0;
      r_tmo         <= '0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_dptr        <= w_dptr_next;
      r_tptr        <= w_tptr_next;
      r_pull_cnt    <= w_pull_cnt_next;
      r_instruction <= w_instruction_next;
      r_data_block  <= w_data_block_next;
      r_txt_block   <= w_txt_block_next;
      r_data_en     <= w_data_en_next;
      r_txt_en      <= w_txt_en_next;
      r_busy        <= w_busy_next;
      r_done        <= w_done_next;
      r_out_data    <= w_out_data_next;
      r_out_valid   <= w_out_valid_next;
      r_out_index   <= w_out_index_next;
`ifdef ASCON_SEQ_TIMEOUT_EN
      r_error       <= w_error_next;
      r_tmo         <= w_tmo_next;
`endif
    end
  end

  assign bus.imem_addr   = r_pc;
  assign bus.dmem_addr   = r_dptr;
  assign bus.tmem_addr   = r_tptr;
  assign bus.instruction = r_instruction;
  assign bus.data_block  = r_data_block;
  assign bus.txt_block   = r_txt_block;
  assign bus.data_blk_en = r_data_en;
  assign bus.txt_blk_en  = r_txt_en;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.out_data    = r_out_data;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_index   = r_out_index;
`ifdef ASCON_SEQ_TIMEOUT_EN
  assign bus.error       = r_error;
`else
  assign bus.error       = 1'b0;
`endif

endmodule

// File: tb/tb_ascon_program_sequencer.sv
// Randomized bench for ascon_program_sequencer: memory and core models plus a program-level
// reference model that predicts the pushed blocks and pulled outputs from the opcode list.
module tb_ascon_program_sequencer;
  localparam int WIDTH = 128;
  localparam int PC_W  = 5;
  localparam int BLK_W = 3;
  localparam logic [5:0] OP_D = 6'h01;
  localparam logic [5:0] OP_T = 6'h02;
  localparam logic [5:0] OP_P = 6'h03;
  localparam logic [5:0] OP_H = 6'h3f;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  ascon_program_sequencer_if #(.WIDTH(WIDTH), .PC_W(PC_W), .BLK_W(BLK_W)) bus ();

  ascon_program_sequencer #(.WIDTH(WIDTH), .PC_W(PC_W), .BLK_W(BLK_W), .TMO_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [5:0]       imem [32];
  logic [WIDTH-1:0] dmem [8];
  logic [WIDTH-1:0] tmem [8];
  logic [WIDTH-1:0] pull_val [64];

  logic [WIDTH-1:0] obs_data[$], obs_txt[$], obs_odat[$], exp_data[$], exp_txt[$], exp_odat[$];
  logic [BLK_W-1:0] obs_oidx[$], exp_oidx[$];
  int               data_times[$];
  int cyc = 0, done_cnt = 0, pulls_seen = 0, core_mode = 0, tmr = 0;
  logic core_level = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Synchronous-read memories
  always @(posedge clk) begin
    bus.imem_data <= imem[bus.imem_addr];
    bus.dmem_data <= dmem[bus.dmem_addr];
    bus.tmem_data <= tmem[bus.tmem_addr];
  end

  // Monitor and core model, evaluated 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.data_blk_en || bus.txt_blk_en)
      check_val("strobe_excl", 128'(bus.data_blk_en & bus.txt_blk_en), 128'd0);
    if (bus.data_blk_en) begin
      check_val("data_op", 128'(bus.instruction), 128'(OP_D));
      obs_data.push_back(bus.data_block);
      data_times.push_back(cyc);
    end
    if (bus.txt_blk_en) begin
      check_val("txt_op", 128'(bus.instruction), 128'(OP_T));
      obs_txt.push_back(bus.txt_block);
    end
    if (bus.out_valid) begin
      obs_oidx.push_back(bus.out_index);
      obs_odat.push_back(bus.out_data);
      pulls_seen++;
    end
    if (bus.done) done_cnt++;
    case (core_mode)
      0: bus.core_next = core_level;
      1: bus.core_next = ($urandom_range(0, 2) != 0);
      default: begin
        // ready stays stale through the strobe cycle, then returns 10 cycles after it
        if (bus.data_blk_en || bus.txt_blk_en) tmr = 10;
        else if (tmr > 0) begin
          tmr--;
          bus.core_next = (tmr == 0);
        end
      end
    endcase
    bus.ascon_out = pull_val[pulls_seen % 64];
  end

  task automatic clear_obs();
    obs_data.delete(); obs_txt.delete(); obs_odat.delete(); obs_oidx.delete();
    data_times.delete();
    done_cnt   = 0;
    pulls_seen = 0;
  endtask

  // Reference model: walk the program from base and list what the core must receive
  task automatic build_expect(input logic [PC_W-1:0] base);
    logic [PC_W-1:0]  pc;
    logic [BLK_W-1:0] dp, tp;
    int k;
    exp_data.delete(); exp_txt.delete(); exp_odat.delete(); exp_oidx.delete();
    pc = base; dp = '0; tp = '0; k = 0;
    for (int s = 0; s < 40 && imem[pc] != OP_H; s++) begin
      if (imem[pc] == OP_D) begin exp_data.push_back(dmem[dp]); dp++; end
      else if (imem[pc] == OP_T) begin exp_txt.push_back(tmem[tp]); tp++; end
      else if (imem[pc] == OP_P) begin
        exp_oidx.push_back(BLK_W'(k % 8));
        exp_odat.push_back(pull_val[k % 64]);
        k++;
      end
      pc++;
    end
  endtask

  task automatic compare_run(input string tag);
    check_val({tag, "_ndata"}, 128'(obs_data.size()), 128'(exp_data.size()));
    check_val({tag, "_ntxt"},  128'(obs_txt.size()),  128'(exp_txt.size()));
    check_val({tag, "_nout"},  128'(obs_odat.size()), 128'(exp_odat.size()));
    for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++)
      check_val({tag, "_data"}, obs_data[i], exp_data[i]);
    for (int i = 0; i < obs_txt.size() && i < exp_txt.size(); i++)
      check_val({tag, "_txt"}, obs_txt[i], exp_txt[i]);
    for (int i = 0; i < obs_odat.size() && i < exp_odat.size(); i++) begin
      check_val({tag, "_odat"}, obs_odat[i], exp_odat[i]);
      check_val({tag, "_oidx"}, 128'(obs_oidx[i]), 128'(exp_oidx[i]));
    end
  endtask

  task automatic run_prog(input string tag, input logic [PC_W-1:0] base, input bit inject);
    int n;
    clear_obs();
    build_expect(base);
    bus.prog_base = base;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.prog_base = PC_W'($urandom_range(0, 31));
    check_val({tag, "_busy_on"}, 128'(bus.busy), 128'd1);
    n = 0;
    while (bus.busy && n < 3000) begin
      bus.start = (inject && n == 6);
      @(posedge clk); #2;
      n++;
    end
    bus.start = 1'b0;
    check_val({tag, "_finished"}, 128'(n < 3000), 128'd1);
    check_val({tag, "_done_cnt"}, 128'(done_cnt), 128'd1);
    check_val({tag, "_halt_op"}, 128'(bus.instruction), 128'(OP_H));
    compare_run(tag);
  endtask

  logic [5:0] ops [4];
  int len, n;
  logic [PC_W-1:0] base;

  initial begin
    ops = '{OP_D, OP_T, OP_P, 6'h05};
    bus.start = 1'b0;
    bus.prog_base = '0;
    bus.core_next = 1'b0;
    bus.ascon_out = '0;
    for (int i = 0; i < 32; i++) imem[i] = OP_H;
    for (int i = 0; i < 8; i++) begin
      dmem[i] = WIDTH'(i + 1);
      tmem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int i = 0; i < 64; i++) pull_val[i] = WIDTH'(8'hA0 + i);

    // Reset held 2 cycles; core not ready until later
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    check_val("rst_busy", 128'(bus.busy), 128'd0);
    check_val("rst_instr", 128'(bus.instruction), 128'(OP_H));
    check_val("rst_done", 128'(bus.done), 128'd0);
    check_val("rst_error", 128'(bus.error), 128'd0);
    check_val("rst_strobes", 128'({bus.data_blk_en, bus.txt_blk_en, bus.out_valid}), 128'd0);
    check_val("rst_addrs", 128'({bus.imem_addr, bus.dmem_addr, bus.tmem_addr}), 128'd0);
    check_val("rst_out", 128'({bus.out_index, bus.out_data}), 128'd0);
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    @(posedge clk); #2;
    check_val("early_start_ignored", 128'(bus.busy), 128'd0);
    core_level = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Data and text pushes with immediate ready: 4 cycles per step
    for (int i = 0; i < 3; i++) imem[4 + i] = OP_D;
    for (int i = 0; i < 4; i++) imem[7 + i] = OP_T;
    imem[11] = OP_H;
    run_prog("push", 5'd4, 1'b0);
    for (int i = 1; i < data_times.size(); i++)
      check_val("push_step4", 128'(data_times[i] - data_times[i-1]), 128'd4);

    // Four pulls
    for (int i = 0; i < 4; i++) imem[12 + i] = OP_P;
    imem[16] = OP_H;
    run_prog("pull", 5'd12, 1'b0);

    // Slow core with stale ready during the strobe cycle: 13 cycles per step
    for (int i = 0; i < 4; i++) imem[20 + i] = OP_D;
    imem[24] = OP_H;
    core_mode = 2;
    run_prog("timed", 5'd20, 1'b0);
    for (int i = 1; i < data_times.size(); i++)
      check_val("timed_step13", 128'(data_times[i] - data_times[i-1]), 128'd13);

    // Reset during WAIT of step 3, then rerun from scratch
    imem[25] = OP_D; imem[26] = OP_T; imem[27] = OP_D; imem[28] = OP_T; imem[29] = OP_D;
    imem[30] = OP_H;
    clear_obs();
    bus.prog_base = 5'd25;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    n = 0;
    while ((obs_data.size() + obs_txt.size()) < 3 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check_val("abort_reach_step3", 128'(n < 200), 128'd1);
    @(posedge clk); #2;
    rstn = 1'b0;
    @(posedge clk); #2;
    check_val("abort_strobes", 128'({bus.data_blk_en, bus.txt_blk_en}), 128'd0);
    check_val("abort_instr", 128'(bus.instruction), 128'(OP_H));
    check_val("abort_busy", 128'(bus.busy), 128'd0);
    rstn = 1'b1;
    core_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    check_val("abort_no_done", 128'(done_cnt), 128'd0);
    core_mode = 1;
    run_prog("rerun", 5'd25, 1'b0);

    // Watchdog
    core_mode = 0;
    imem[0] = OP_D; imem[1] = OP_H;
    clear_obs();
    core_level = 1'b0;
    bus.prog_base = 5'd0;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
`ifdef ASCON_SEQ_TIMEOUT_EN
    repeat (17) @(posedge clk);
    #2;
    check_val("tmo_not_yet", 128'({bus.error, bus.busy}), 128'b01);
    @(posedge clk); #2;
    check_val("tmo_error", 128'(bus.error), 128'd1);
    check_val("tmo_busy", 128'(bus.busy), 128'd0);
    check_val("tmo_instr", 128'(bus.instruction), 128'(OP_H));
    check_val("tmo_no_done", 128'(done_cnt), 128'd0);
    core_level = 1'b1;
    @(posedge clk); #2;
    run_prog("tmo_clear", 5'd0, 1'b0);
    check_val("tmo_error_cleared", 128'(bus.error), 128'd0);
`else
    repeat (40) @(posedge clk);
    #2;
    check_val("no_tmo", 128'({bus.error, bus.busy}), 128'b01);
    rstn = 1'b0;
    @(posedge clk); #2;
    rstn = 1'b1;
    core_level = 1'b1;
    repeat (3) @(posedge clk);
    #2;
`endif

    // Randomized programs with PC/pointer wrap, random core readiness and ignored restarts
    core_mode = 1;
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 32; i++) imem[i] = ops[$urandom_range(0, 3)];
      for (int i = 0; i < 8; i++) begin
        dmem[i] = {$urandom, $urandom, $urandom, $urandom};
        tmem[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int i = 0; i < 64; i++) pull_val[i] = {$urandom, $urandom, $urandom, $urandom};
      base = PC_W'($urandom_range(0, 31));
      len = $urandom_range(3, 20);
      imem[(int'(base) + len) % 32] = OP_H;
      run_prog("rand", base, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
